// File: rtl/pll_dyncfg_ctrl.sv
// PLL dynamic-reconfiguration controller: buffers a batch of register writes, then holds
// the PLL in reset, shifts the writes out as 4-cycle DRP slots, commits them and waits for lock.
module pll_dyncfg_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       cfg_last,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       dclk,
  output logic       dcs,
  output logic       dwe,
  output logic [5:0] daddr,
  output logic [7:0] di,
  output logic       load_reg,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_FREE = CW'(FIFO_DEPTH - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, PLL_RST, WRITE, LOAD, RELEASE, WAIT_LOCK
  } state_e;

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [RW-1:0] rst_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [1:0]    slot_q;
  logic          cur_last_q;
  logic          pll_reset_q, dclk_q, dcs_q, dwe_q, load_reg_q, done_q, err_q;
  logic [5:0]    daddr_q;
  logic [7:0]    di_q;
  logic [14:0]   mem_q [FIFO_DEPTH];

  logic          push_d;
  logic          issue_d;
  logic [14:0]   head_d;

  assign cfg_ready = (count_q != FULL_CNT) && ((state_q == IDLE) || (state_q == FILL));
  assign busy      = (state_q != IDLE);
  assign push_d    = cfg_valid && cfg_ready;
  assign head_d    = mem_q[rd_ptr_q];

  // A slot starts either when the reset hold expires or after c3 of a non-final slot.
  assign issue_d = ((state_q == PLL_RST) && (rst_cnt_q == RST_LAST)) ||
                   ((state_q == WRITE) && (slot_q == 2'd3) && !cur_last_q);

  assign pll_reset = pll_reset_q;
  assign dclk      = dclk_q;
  assign dcs       = dcs_q;
  assign dwe       = dwe_q;
  assign daddr     = daddr_q;
  assign di        = di_q;
  assign load_reg  = load_reg_q;
  assign done      = done_q;
  assign err       = err_q;

  // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge refclk) begin
    if (push_d) mem_q[wr_ptr_q] <= {cfg_last, cfg_addr, cfg_data};
  end

  // NOTE: non-blocking throughout, so later assignments in this block override earlier
  // defaults for the same edge (pulses default low, flush overrides the push update).
  always_ff @(posedge refclk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      slot_q      <= '0;
      cur_last_q  <= 1'b0;
      pll_reset_q <= 1'b0;
      dclk_q      <= 1'b0;
      dcs_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      load_reg_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      load_reg_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 1'b1;
      end

      unique case (state_q)
        IDLE, FILL: begin
          if (push_d) begin
            if (cfg_last) begin
              state_q     <= PLL_RST;
              pll_reset_q <= 1'b1;
              rst_cnt_q   <= '0;
            end else if (count_q == LAST_FREE) begin
              // Buffer filled without a batch terminator: drop everything.
              state_q  <= IDLE;
              err_q    <= 1'b1;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
              count_q  <= '0;
            end else begin
              state_q <= FILL;
            end
          end
        end
        PLL_RST: begin
          if (rst_cnt_q == RST_LAST) state_q <= WRITE;
          else                       rst_cnt_q <= rst_cnt_q + 1'b1;
        end
        WRITE: begin
          unique case (slot_q)
            2'd0: begin
              dclk_q <= 1'b1;
              slot_q <= 2'd1;
            end
            2'd1: begin
              dclk_q <= 1'b0;
              dcs_q  <= 1'b0;
              dwe_q  <= 1'b0;
              slot_q <= 2'd2;
            end
            2'd2: slot_q <= 2'd3;
            2'd3: begin
              if (cur_last_q) begin
                state_q    <= LOAD;
                load_reg_q <= 1'b1;
              end
            end
          endcase
        end
        LOAD: begin
          state_q     <= RELEASE;
          pll_reset_q <= 1'b0;
        end
        RELEASE: begin
          state_q  <= WAIT_LOCK;
          to_cnt_q <= '0;
        end
        WAIT_LOCK: begin
          // Lock wins when it coincides with the final timeout cycle.
          if (pll_lock) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (to_cnt_q == TO_LAST) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (issue_d) begin
        slot_q     <= 2'd0;
        daddr_q    <= head_d[13:8];
        di_q       <= head_d[7:0];
        cur_last_q <= head_d[14];
        dcs_q      <= 1'b1;
        dwe_q      <= 1'b1;
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        count_q    <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// Directed bench for pll_dyncfg_ctrl: commands are queued as expected DRP slots when pushed
// and popped when the controller issues them; timing of reset hold, slots and lock is checked.
module tb_pll_dyncfg_ctrl;

  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int FIFO_DEPTH   = 4;

  logic       refclk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       pll_lock;
  logic       pll_reset;
  logic       dclk, dcs, dwe;
  logic [5:0] daddr;
  logic [7:0] di;
  logic       load_reg, busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [13:0] exp_q [$];

  always #5 refclk = ~refclk;

  pll_dyncfg_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .refclk   (refclk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .dclk     (dclk),
    .dcs      (dcs),
    .dwe      (dwe),
    .daddr    (daddr),
    .di       (di),
    .load_reg (load_reg),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [5:0] a, input logic [7:0] d, input logic l, input bit keep);
    check("ready_before_push", 32'({cfg_ready, pll_reset}), 32'b10);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_last  = l;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (keep) exp_q.push_back({a, d});
  endtask

  task automatic check_slot();
    logic [13:0] e;
    e = '0;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check("c0_ctrl", 32'({dclk, dcs, dwe, pll_reset, cfg_ready}), 32'b01110);
    check("c0_data", 32'({daddr, di}), 32'(e));
    tick();
    check("c1_ctrl", 32'({dclk, dcs, dwe, pll_reset}), 32'b1111);
    tick();
    check("c2_ctrl", 32'({dclk, dcs, dwe, pll_reset}), 32'b0001);
    tick();
    check("c3_ctrl", 32'({dclk, dcs, dwe, pll_reset, load_reg}), 32'b00010);
    check("c3_data_held", 32'({daddr, di}), 32'(e));
    tick();
  endtask

  // lock_delay < 0 means the PLL never locks.
  task automatic run_batch(input int n_slots, input int lock_delay, input bit hold_valid);
    int cyc;
    cyc = 0;
    while (pll_reset && !dcs && busy && cyc < 4 * RST_CYCLES) begin
      cyc++;
      tick();
    end
    check("pll_rst_cycles", cyc, RST_CYCLES);
    if (hold_valid) begin
      cfg_valid = 1'b1;
      cfg_addr  = 6'h3F;
      cfg_data  = 8'hEE;
      cfg_last  = 1'b1;
    end
    for (int s = 0; s < n_slots; s++) check_slot();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    check("load_cycle", 32'({load_reg, pll_reset, busy, dcs, cfg_ready}), 32'b11100);
    tick();
    check("release_cycle", 32'({load_reg, pll_reset, busy, cfg_ready}), 32'b0010);
    tick();
    cyc = 0;
    if (lock_delay >= 0) begin
      while (cyc < lock_delay && busy && !done && !err) begin
        cyc++;
        tick();
      end
      check("wait_before_lock", cyc, lock_delay);
      pll_lock = 1'b1;
      tick();
      pll_lock = 1'b0;
      check("lock_result", 32'({done, err, busy, cfg_ready, pll_reset}), 32'b10010);
      tick();
      check("done_pulse_end", 32'({done, err, busy}), 32'b000);
    end else begin
      while (busy && !err && cyc < LOCK_TIMEOUT + 8) begin
        cyc++;
        tick();
      end
      check("timeout_cycles", cyc, LOCK_TIMEOUT);
      check("timeout_result", 32'({done, err, busy, cfg_ready, pll_reset}), 32'b01010);
      tick();
      check("err_pulse_end", 32'({err, busy}), 32'b00);
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic seen;
    int   cyc;

    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    pll_lock  = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", 32'({pll_reset, dclk, dcs, dwe, load_reg, busy, done, err, cfg_ready}),
          32'b000000001);
    check("rst_data", 32'({daddr, di}), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_after_rst", 32'({busy, cfg_ready, pll_reset}), 32'b010);

    // Single-command batch, lock 10 cycles into the wait.
    push_cmd(6'h05, 8'hA1, 1'b1, 1'b1);
    run_batch(1, 10, 1'b0);

    // Three-command batch; cfg_valid held high through WRITE must be ignored.
    // Lock arrives on the final timeout cycle and must count as success.
    push_cmd(6'h10, 8'h11, 1'b0, 1'b1);
    check("fill_busy", 32'({busy, cfg_ready}), 32'b11);
    push_cmd(6'h2A, 8'hB2, 1'b0, 1'b1);
    push_cmd(6'h3F, 8'hC3, 1'b1, 1'b1);
    run_batch(3, LOCK_TIMEOUT - 1, 1'b1);

    // A stray command accepted during WRITE would surface here ahead of this one.
    push_cmd(6'h0C, 8'h5D, 1'b1, 1'b1);
    run_batch(1, -1, 1'b0);

    // Overflow: FIFO_DEPTH commands without a terminator.
    for (int i = 0; i < FIFO_DEPTH; i++) push_cmd(6'(i + 1), 8'(8'h70 + i), 1'b0, 1'b0);
    check("overflow_result", 32'({err, busy, pll_reset, cfg_ready}), 32'b1001);
    tick();
    check("overflow_pulse_end", 32'({err, busy, pll_reset}), 32'b000);

    // After the flush only the new command may be issued.
    push_cmd(6'h22, 8'h9C, 1'b1, 1'b1);
    run_batch(1, 3, 1'b0);

    // Reset asserted during c1 of a slot.
    push_cmd(6'h21, 8'h5A, 1'b1, 1'b1);
    cyc = 0;
    while (!dclk && cyc < 4 * RST_CYCLES) begin
      cyc++;
      tick();
    end
    check("reached_c1", 32'({dclk, dcs, dwe}), 32'b111);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    check("abort_ctrl", 32'({dclk, dcs, dwe, pll_reset, busy, load_reg, cfg_ready}), 32'b0000001);
    check("abort_data", 32'({daddr, di}), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | dcs | dwe | dclk | pll_reset | busy;
    end
    check("no_partial_slot", 32'(seen), 32'd0);

    // Normal operation resumes; immediate lock on the first wait cycle.
    push_cmd(6'h33, 8'h44, 1'b1, 1'b1);
    run_batch(1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_dyncfg_ctrl.md
PLL_DYNCFG_CTRL -- requirements
Module: pll_dyncfg_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, the number of refclk cycles pll_reset is held asserted before writes begin.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, the number of refclk cycles to wait for pll_lock after release.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the command buffer entries (power of two).
REQ-004 SHALL have port refclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1, the command write strobe.
REQ-007 SHALL have port cfg_ready, output, 1, high when the FIFO is not full and the state is IDLE or FILL.
REQ-008 SHALL have port cfg_addr, input, 6, the PLL register address.
REQ-009 SHALL have port cfg_data, input, 8, the PLL register data.
REQ-010 SHALL have port cfg_last, input, 1, which marks the final command of a reconfiguration batch.
REQ-011 SHALL have port pll_lock, input, 1, the PLL lock indicator, already synchronous to refclk.
REQ-012 SHALL have port pll_reset, output, 1, an active-high reset to the PLL.
REQ-013 SHALL have port dclk, output, 1, the dynamic-config clock.
REQ-014 SHALL have port dcs, output, 1, the dynamic-config chip select.
REQ-015 SHALL have port dwe, output, 1, the dynamic-config write enable.
REQ-016 SHALL have port daddr, output, 6, the dynamic-config address.
REQ-017 SHALL have port di, output, 8, the dynamic-config write data.
REQ-018 SHALL have port load_reg, output, 1, a one-refclk-cycle pulse that commits the written registers.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-020 SHALL have port done, output, 1, a one-cycle pulse on successful lock.
REQ-021 SHALL have port err, output, 1, a one-cycle pulse on lock timeout or FIFO overflow.

Function
REQ-022 SHALL accept a command on a refclk edge where cfg_valid and cfg_ready are both high, pushing {cfg_last, cfg_addr, cfg_data} into the FIFO.
REQ-023 SHALL use FSM states IDLE, FILL, PLL_RST, WRITE, LOAD, RELEASE, WAIT_LOCK.
REQ-024 SHALL transition IDLE->FILL on the first accepted command, or IDLE->PLL_RST if that command has cfg_last set.
REQ-025 SHALL transition FILL->PLL_RST on the cycle after an accepted command with cfg_last set.
REQ-026 SHALL, if the FIFO fills with no cfg_last, pulse err, flush the FIFO and return to IDLE.
REQ-027 SHALL, in PLL_RST, hold pll_reset=1 for exactly RST_CYCLES cycles, then go to WRITE.
REQ-028 SHALL, in WRITE, issue each FIFO entry as a 4-cycle slot with pll_reset held 1 throughout:
  - c0: daddr/di driven, dcs=dwe=1, dclk=0
  - c1: dclk=1, the PLL sampling edge
  - c2: dclk=0, dcs=dwe=0
  - c3: idle gap
REQ-029 SHALL pop one FIFO entry per slot, and after the slot carrying last go to LOAD.
REQ-030 SHALL, in LOAD, pulse load_reg for 1 cycle, then go to RELEASE.
REQ-031 SHALL, in RELEASE, drive pll_reset=0 and go to WAIT_LOCK on the next cycle with the timeout counter cleared.
REQ-032 SHALL, in WAIT_LOCK, on pll_lock=1 pulse done and go to IDLE.
REQ-033 SHALL, in WAIT_LOCK, after LOCK_TIMEOUT cycles without lock, pulse err and go to IDLE.
REQ-034 SHALL, if pll_lock and the timeout occur in the same cycle, treat it as success.
REQ-035 SHALL hold dclk, dcs, dwe and load_reg at 0 outside their defined slots, and keep daddr/di at their last value.
REQ-036 SHALL hold cfg_ready low from PLL_RST through WAIT_LOCK.
REQ-037 SHALL size counters to ceil(log2) of their parameter, with no wrap before terminal count.

Reset
REQ-038 SHALL, while reset=0 at a refclk edge, enter IDLE, empty the FIFO and clear all counters.
REQ-039 SHALL reset outputs to: pll_reset=0, dclk=0, dcs=0, dwe=0, daddr=0, di=0, load_reg=0, busy=0, done=0, err=0, cfg_ready=1.
REQ-040 SHALL abort any state immediately on reset, including mid-slot, with no partial dcs/dwe pulse completing afterward.

Verification
REQ-041 SHALL cover: push (0x05,0xA1,last) -> pll_reset high 16 cycles; one slot with daddr=0x05, di=0xA1; load_reg pulse; pll_reset low; pll_lock at +10 -> done pulse, busy low.
REQ-042 SHALL cover: push 3 commands, the last with cfg_last -> 3 slots in FIFO order spaced 4 cycles; dclk high only in c1 of each slot.
REQ-043 SHALL cover: pll_lock held 0 -> err pulse exactly LOCK_TIMEOUT cycles after RELEASE; return to IDLE; cfg_ready=1.
REQ-044 SHALL cover: push 4 commands without cfg_last -> err pulse, FIFO flushed, no pll_reset assertion.
REQ-045 SHALL cover: reset=0 during c1 of a slot -> next cycle dclk=0, dcs=0, pll_reset=0, busy=0.
REQ-046 SHALL cover: cfg_valid held high during WRITE -> no command accepted, FIFO count unchanged.
